// File: rtl/fetch_unit.sv
// Opcode fetch stage: owns the PC, loads it from the reset vector, reads opcode
// bytes (folding $10/$11 page prefixes) and presents a 16-bit instruction word.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_START  | idle cycle after reset release, no memory access
// ST_VEC_HI | reading vector high byte at RESET_VECTOR
// ST_VEC_LO | reading vector low byte at RESET_VECTOR+1
// ST_FETCH  | reading opcode (or page prefix) byte at pc
// ST_FETCH2 | reading opcode byte that follows a page prefix
// ST_HOLD   | ir valid, waiting for ir_ack; pc_inc/pc_load honoured here

module fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_din,
    input  logic        mem_ack,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ir_ack,
    output logic [15:0] pc,
    input  logic        pc_inc,
    input  logic        pc_load,
    input  logic [15:0] pc_in
);

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_VEC_HI = 3'd1,
        ST_VEC_LO = 3'd2,
        ST_FETCH  = 3'd3,
        ST_FETCH2 = 3'd4,
        ST_HOLD   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        mem_rd_q, mem_rd_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        rd_done;

    assign rd_done = mem_rd_q & mem_ack;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_START: state_d = ST_VEC_HI;
            ST_VEC_HI: begin
                if (rd_done) begin
                    pc_d[15:8] = mem_din;
                    state_d    = ST_VEC_LO;
                end
            end
            ST_VEC_LO: begin
                if (rd_done) begin
                    pc_d[7:0] = mem_din;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (rd_done) begin
                    pc_d = pc_q + 16'd1;
                    if (mem_din == 8'h10 || mem_din == 8'h11) begin
                        ir_d[15:8] = mem_din;
                        state_d    = ST_FETCH2;
                    end else begin
                        ir_d    = {8'h00, mem_din};
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_FETCH2: begin
                // Second byte is always the opcode; prefixes do not chain.
                if (rd_done) begin
                    ir_d[7:0] = mem_din;
                    pc_d      = pc_q + 16'd1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pc_load) begin
                    pc_d = pc_in;
                end else if (pc_inc) begin
                    pc_d = pc_q + 16'd1;
                end
                if (ir_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    // Outputs are registered from the next state and next pc, so they never
    // see mem_ack, ir_ack or mem_din combinationally.
    always_comb begin
        mem_rd_d   = 1'b0;
        mem_addr_d = pc_d;
        ir_valid_d = 1'b0;
        case (state_d)
            ST_VEC_HI: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = RESET_VECTOR;
            end
            ST_VEC_LO: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = RESET_VECTOR + 16'd1;
            end
            ST_FETCH, ST_FETCH2: mem_rd_d = 1'b1;
            ST_HOLD:             ir_valid_d = 1'b1;
            default:             mem_rd_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_START;
            pc_q       <= 16'h0000;
            ir_q       <= 16'h0000;
            ir_valid_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign pc       = pc_q;

endmodule
